// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 4-digit seven-segment scanner with frame-aligned double buffering
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load              one-cycle strobe capturing value/dp_in into the shadow register
//   value[15:0]       hex value, [3:0] is digit 0 (rightmost)
//   dp_in[3:0]        active-high decimal-point request per digit
//   blank_lz          leading-zero blanking enable
//   nibble[3:0]       nibble of the lit digit, to the hex decoder
//   an[3:0]           active-low anode enables
//   dp                active-low decimal-point segment
//   frame_done        one-cycle pulse when digit 0 of a new frame lights
module seg_scan_mux #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] r_div;
    logic [1:0]    r_idx;
    logic          r_run;
    logic          r_pending;
    logic [15:0]   r_sh_val;
    logic [15:0]   r_ds_val;
    logic [3:0]    r_sh_dp;
    logic [3:0]    r_ds_dp;
    logic          w_tick;
    logic          w_bound;
    logic          w_blank;
    logic [1:0]    w_idx;
    logic [15:0]   w_ds_val;
    logic [15:0]   w_shift;
    logic [3:0]    w_ds_dp;
    // r_run holds the divider on the first edge out of reset so digit 0 gets its full CLK_DIV cycles
    always_comb begin
        w_tick   = r_run && (r_div == DW'(CLK_DIV - 1));
        w_bound  = w_tick && (r_idx == 2'd3);
        w_idx    = w_tick ? r_idx + 2'd1 : r_idx;
        w_ds_val = !w_bound ? r_ds_val : load ? value : r_pending ? r_sh_val : r_ds_val;
        w_ds_dp  = !w_bound ? r_ds_dp : load ? dp_in : r_pending ? r_sh_dp : r_ds_dp;
        // nibbles idx..3 all zero means the digit is a leading zero
        w_shift  = w_ds_val >> {w_idx, 2'b00};
        w_blank  = blank_lz && (w_idx != 2'd0) && (w_shift == 16'h0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_idx      <= 2'd0;
            r_run      <= 1'b0;
            r_pending  <= 1'b0;
            r_sh_val   <= 16'h0;
            r_sh_dp    <= 4'h0;
            r_ds_val   <= 16'h0;
            r_ds_dp    <= 4'h0;
            nibble     <= 4'h0;
            an         <= 4'hF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_div      <= (w_tick || !r_run) ? '0 : r_div + DW'(1);
            r_idx      <= w_idx;
            r_sh_val   <= load ? value : r_sh_val;
            r_sh_dp    <= load ? dp_in : r_sh_dp;
            r_pending  <= !w_bound && (load || r_pending);
            r_ds_val   <= w_ds_val;
            r_ds_dp    <= w_ds_dp;
            nibble     <= w_shift[3:0];
            an         <= w_blank ? 4'hF : ~(4'b0001 << w_idx);
            dp         <= w_blank | ~w_ds_dp[w_idx];
            frame_done <= w_bound;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: self-checking bench for seg_scan_mux against a time-based display model
module tb_seg_scan_mux;
    localparam int D = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;
    int checks = 0;
    int errors = 0;

    seg_scan_mux #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .nibble(nibble), .an(an), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Model: t counts edges since reset release; slot = (t-1)/D, a new frame starts every 4*D edges
    // and shows the last value loaded at or before its first edge.
    bit          m_valid = 0;
    int          t;
    logic [15:0] latest_v, disp_v;
    logic [3:0]  latest_d, disp_d;
    logic [1:0]  dg;
    bit          bl;
    logic [3:0]  e_nib, e_an;
    logic        e_dp, e_fd;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; t = 0;
            latest_v = 0; latest_d = 0; disp_v = 0; disp_d = 0;
            e_nib = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
        end else if (m_valid) begin
            t++;
            if (load) begin latest_v = value; latest_d = dp_in; end
            e_fd = (t > 1) && ((t - 1) % (4 * D) == 0);
            if (e_fd) begin disp_v = latest_v; disp_d = latest_d; end
            dg = 2'(((t - 1) / D) % 4);
            e_nib = 4'((disp_v >> (4 * dg)) & 16'hF);
            bl = blank_lz && (dg != 2'd0) && ((disp_v >> (4 * dg)) == 16'h0);
            e_an = bl ? 4'hF : ~(4'b0001 << dg);
            e_dp = bl | ~disp_d[dg];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_nibble", nibble, e_nib);
            chk("m_an", an, e_an);
            chk("m_dp", dp, e_dp);
            chk("m_frame_done", frame_done, e_fd);
        end
    end

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_done timeout actual=none required=pulse");
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_an", an, 4'hF);
        chk("rst_nibble", nibble, 4'h0);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", an, 4'hE);
        chk("first_nibble", nibble, 4'h0);
        chk("first_dp", dp, 1'b1);
        wait_fd(n);
        chk("first_frame_len", n, 16);
        wait_fd(n);
        chk("frame_period", n, 16);
        // mid-frame load
        repeat (5) @(negedge clk);
        do_load(16'h1A2F, 4'b0100);
        wait_fd(n);
        chk("load_d0", nibble, 4'hF);
        repeat (8) @(negedge clk);
        chk("load_d2_an", an, 4'b1011);
        chk("load_d2_nib", nibble, 4'hA);
        chk("load_d2_dp", dp, 1'b0);
        // two loads in one frame
        wait_fd(n);
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'h0);
        @(negedge clk);
        do_load(16'h2222, 4'h0);
        wait_fd(n);
        chk("last_load_wins", nibble, 4'h2);
        // load coincident with frame boundary
        repeat (15) @(negedge clk);
        do_load(16'h00C3, 4'h0);
        chk("bound_nib", nibble, 4'h3);
        chk("bound_fd", frame_done, 1'b1);
        chk("bound_an", an, 4'hE);
        chk("bound_pending", dut.r_pending, 1'b0);
        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0000, 4'h0);
        wait_fd(n);
        repeat (4) @(negedge clk);
        chk("blank0_d1", an, 4'hF);
        do_load(16'h0050, 4'h0);
        wait_fd(n);
        repeat (4) @(negedge clk);
        chk("blank50_d1_an", an, 4'b1101);
        chk("blank50_d1_nib", nibble, 4'h5);
        repeat (4) @(negedge clk);
        chk("blank50_d2", an, 4'hF);
        do_load(16'h1000, 4'h0);
        wait_fd(n);
        repeat (12) @(negedge clk);
        chk("blank1000_d3_an", an, 4'b0111);
        chk("blank1000_d3_nib", nibble, 4'h1);
        do_load(16'h0000, 4'h0);
        wait_fd(n);
        repeat (5) @(negedge clk);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        blank_lz = 1'b1;
        repeat (6) @(negedge clk);
        // reset in digit 2 with a load pending; load during reset ignored
        wait_fd(n);
        repeat (9) @(negedge clk);
        do_load(16'hBEEF, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b1; value = 16'h7777; load = 1'b1;
        @(negedge clk);
        chk_reset();
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("rerun_an", an, 4'hE);
        chk("rerun_nib", nibble, 4'h0);
        wait_fd(n);
        chk("rerun_frame_len", n, 16);
        chk("pending_lost", nibble, 4'h0);
        wait_fd(n);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
